// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes MIPS-style instructions into ALU op/operands behind a two-entry skid buffer
module alu_issue_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Flush,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Instr,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [3:0]  ALUControl,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  WriteReg,
    output logic        RegWrite,
    output logic        Illegal,
    output logic [15:0] IssueCount
);
    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wr;
        logic        rw;
        logic        ill;
    } entry_t;

    entry_t dec, head, skid;
    logic skid_valid;
    logic [5:0] op, funct;
    logic [4:0] rt, rd;
    logic [31:0] sext, zext;
    logic in_xfer, out_xfer;

    assign op       = Instr[31:26];
    assign funct    = Instr[5:0];
    assign rt       = Instr[20:16];
    assign rd       = Instr[15:11];
    assign sext     = {{16{Instr[15]}}, Instr[15:0]};
    assign zext     = {16'h0000, Instr[15:0]};
    assign InReady  = !Rst && !skid_valid;
    assign in_xfer  = InValid && InReady;
    assign out_xfer = OutValid && OutReady;

    assign ALUControl = head.ctl;
    assign A          = head.a;
    assign B          = head.b;
    assign WriteReg   = head.wr;
    assign RegWrite   = head.rw;
    assign Illegal    = head.ill;

    // Decode at the input so both buffered entries hold ready-to-issue fields
    always_comb begin
        dec = '0;
        dec.ctl = 4'd2;
        case (op)
            6'h00: begin
                dec.a = RsData;
                dec.b = RtData;
                dec.wr = rd;
                dec.rw = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec.ctl = 4'd2;
                    6'h22, 6'h23: dec.ctl = 4'd6;
                    6'h24: dec.ctl = 4'd0;
                    6'h25: dec.ctl = 4'd1;
                    6'h27: dec.ctl = 4'd3;
                    6'h2A: dec.ctl = 4'd7;
                    6'h00: begin
                        dec.ctl = 4'd10;
                        dec.a = RtData;
                        dec.b = zext;
                    end
                    6'h08: begin
                        dec.ctl = 4'd8;
                        dec.b = '0;
                        dec.rw = 1'b0;
                    end
                    default: dec.ill = 1'b1;
                endcase
            end
            6'h1C: begin
                dec.a = RsData;
                dec.wr = rd;
                dec.rw = 1'b1;
                case (funct)
                    6'h02: begin
                        dec.ctl = 4'd9;
                        dec.b = RtData;
                    end
                    6'h21: begin
                        dec.ctl = 4'd12;
                        dec.b = 32'd1;
                    end
                    6'h20: dec.ctl = 4'd12;
                    default: dec.ill = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h0A, 6'h0C, 6'h0D: begin
                dec.ctl = (op == 6'h0A) ? 4'd7 : (op == 6'h0C) ? 4'd0 : (op == 6'h0D) ? 4'd1 : 4'd2;
                dec.a = RsData;
                dec.b = (op == 6'h0C || op == 6'h0D) ? zext : sext;
                dec.wr = rt;
                dec.rw = 1'b1;
            end
            6'h2B: begin
                dec.a = RsData;
                dec.b = sext;
            end
            6'h04, 6'h05: begin
                dec.ctl = 4'd6;
                dec.a = RsData;
                dec.b = RtData;
            end
            6'h02: dec.ctl = 4'd8;
            6'h03: begin
                dec.ctl = 4'd8;
                dec.wr = 5'd31;
                dec.rw = 1'b1;
            end
            default: dec.ill = 1'b1;
        endcase
        if (dec.ill) begin
            dec = '0;
            dec.ctl = 4'd2;
            dec.ill = 1'b1;
        end
    end

    // Output register refills from the skid entry first, then from the input; stalled input goes to skid
    always_ff @(posedge Clk) begin
        if (Rst) begin
            head <= '0;
            skid <= '0;
            OutValid <= 1'b0;
            skid_valid <= 1'b0;
            IssueCount <= '0;
        end else begin
            if (out_xfer) IssueCount <= IssueCount + 16'd1;
            if (Flush) begin
                OutValid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!OutValid || OutReady) begin
                if (skid_valid) begin
                    head <= skid;
                    OutValid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    OutValid <= in_xfer;
                    if (in_xfer) head <= dec;
                end
            end else if (in_xfer) begin
                skid <= dec;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed per-feature tests for alu_issue_stage
module tb_alu_issue_stage;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Flush = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] Instr = '0;
    logic [31:0] RsData = '0;
    logic [31:0] RtData = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  WriteReg;
    logic        RegWrite;
    logic        Illegal;
    logic [15:0] IssueCount;
    int n_checks = 0;
    int n_errors = 0;

    alu_issue_stage dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .Instr(Instr), .RsData(RsData), .RtData(RtData), .OutValid(OutValid), .OutReady(OutReady),
        .ALUControl(ALUControl), .A(A), .B(B), .WriteReg(WriteReg), .RegWrite(RegWrite),
        .Illegal(Illegal), .IssueCount(IssueCount)
    );

    always #5 Clk = ~Clk;

    // one rising edge, then settle on the falling edge where checks happen
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic apply_reset();
        Rst = 1'b1;
        Flush = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b0;
        tick();
        Rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        Instr = i;
        RsData = rs;
        RtData = rt;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        InValid = 1'b1;
        OutReady = 1'b1;
        Instr = 32'h012A4020;
        tick();
        n_checks++; if (OutValid !== 1'b0) begin n_errors++; $display("FAIL rst_outvalid: got %0d exp 0", OutValid); end
        n_checks++; if (InReady !== 1'b0) begin n_errors++; $display("FAIL rst_inready: got %0d exp 0", InReady); end
        n_checks++; if ({ALUControl, A, B, WriteReg, RegWrite, Illegal, IssueCount} !== '0) begin n_errors++; $display("FAIL rst_fields: got ctl=%0d A=%h B=%h wr=%0d rw=%0d ill=%0d cnt=%0d exp all 0", ALUControl, A, B, WriteReg, RegWrite, Illegal, IssueCount); end
        Rst = 1'b0;
        InValid = 1'b0;
        #1;
        n_checks++; if (InReady !== 1'b1) begin n_errors++; $display("FAIL rst_release_inready: got %0d exp 1", InReady); end
        n_checks++; if (OutValid !== 1'b0) begin n_errors++; $display("FAIL rst_release_outvalid: got %0d exp 0", OutValid); end
    endtask

    task automatic test_add();
        apply_reset();
        OutReady = 1'b1;
        send(32'h012A4020, 32'd5, 32'd7);
        n_checks++; if (OutValid !== 1'b1) begin n_errors++; $display("FAIL add_valid: got %0d exp 1", OutValid); end
        n_checks++; if ({ALUControl, A, B, WriteReg, RegWrite, Illegal} !== {4'd2, 32'd5, 32'd7, 5'd8, 1'b1, 1'b0}) begin n_errors++; $display("FAIL add_fields: got ctl=%0d A=%h B=%h wr=%0d rw=%0d ill=%0d exp ctl=2 A=5 B=7 wr=8 rw=1 ill=0", ALUControl, A, B, WriteReg, RegWrite, Illegal); end
        tick();
        n_checks++; if (IssueCount !== 16'd1) begin n_errors++; $display("FAIL add_count: got %0d exp 1", IssueCount); end
        n_checks++; if (OutValid !== 1'b0) begin n_errors++; $display("FAIL add_drain: got %0d exp 0", OutValid); end
    endtask

    task automatic test_imm();
        apply_reset();
        OutReady = 1'b1;
        send(32'h2128FFFF, 32'h10, 32'h99);
        n_checks++; if ({ALUControl, A, B, WriteReg, RegWrite} !== {4'd2, 32'h10, 32'hFFFFFFFF, 5'd8, 1'b1}) begin n_errors++; $display("FAIL addi: got ctl=%0d A=%h B=%h wr=%0d rw=%0d exp ctl=2 A=10 B=ffffffff wr=8 rw=1", ALUControl, A, B, WriteReg, RegWrite); end
        send(32'h3128FFFF, 32'h20, 32'h99);
        n_checks++; if ({ALUControl, A, B, WriteReg} !== {4'd0, 32'h20, 32'h0000FFFF, 5'd8}) begin n_errors++; $display("FAIL andi: got ctl=%0d A=%h B=%h wr=%0d exp ctl=0 A=20 B=0000ffff wr=8", ALUControl, A, B, WriteReg); end
        send(32'hAD28FFF0, 32'h30, 32'h99);
        n_checks++; if ({ALUControl, A, B, RegWrite} !== {4'd2, 32'h30, 32'hFFFFFFF0, 1'b0}) begin n_errors++; $display("FAIL sw: got ctl=%0d A=%h B=%h rw=%0d exp ctl=2 A=30 B=fffffff0 rw=0", ALUControl, A, B, RegWrite); end
        n_checks++; if (IssueCount !== 16'd2) begin n_errors++; $display("FAIL imm_count: got %0d exp 2", IssueCount); end
    endtask

    task automatic test_misc_decode();
        apply_reset();
        OutReady = 1'b1;
        send(32'h00094080, 32'd9, 32'd3);
        n_checks++; if ({ALUControl, A, B, WriteReg, RegWrite} !== {4'd10, 32'd3, 32'h00004080, 5'd8, 1'b1}) begin n_errors++; $display("FAIL sll: got ctl=%0d A=%h B=%h wr=%0d rw=%0d exp ctl=10 A=3 B=4080 wr=8 rw=1", ALUControl, A, B, WriteReg, RegWrite); end
        n_checks++; if (B[10:6] !== 5'd2) begin n_errors++; $display("FAIL sll_shamt: got %0d exp 2", B[10:6]); end
        send(32'h71204021, 32'h55, 32'h66);
        n_checks++; if ({ALUControl, A, B, WriteReg, RegWrite} !== {4'd12, 32'h55, 32'd1, 5'd8, 1'b1}) begin n_errors++; $display("FAIL clo: got ctl=%0d A=%h B=%h wr=%0d rw=%0d exp ctl=12 A=55 B=1 wr=8 rw=1", ALUControl, A, B, WriteReg, RegWrite); end
        send(32'hFC000000, 32'h55, 32'h66);
        n_checks++; if ({ALUControl, A, B, WriteReg, RegWrite, Illegal, OutValid} !== {4'd2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1}) begin n_errors++; $display("FAIL illegal: got ctl=%0d A=%h B=%h wr=%0d rw=%0d ill=%0d v=%0d exp ctl=2 A=0 B=0 wr=0 rw=0 ill=1 v=1", ALUControl, A, B, WriteReg, RegWrite, Illegal, OutValid); end
        send(32'h0C000010, 32'h55, 32'h66);
        n_checks++; if ({ALUControl, A, B, WriteReg, RegWrite, Illegal} !== {4'd8, 32'd0, 32'd0, 5'd31, 1'b1, 1'b0}) begin n_errors++; $display("FAIL jal: got ctl=%0d A=%h B=%h wr=%0d rw=%0d ill=%0d exp ctl=8 A=0 B=0 wr=31 rw=1 ill=0", ALUControl, A, B, WriteReg, RegWrite, Illegal); end
        send(32'h11090004, 32'h11, 32'h22);
        n_checks++; if ({ALUControl, A, B, RegWrite} !== {4'd6, 32'h11, 32'h22, 1'b0}) begin n_errors++; $display("FAIL beq: got ctl=%0d A=%h B=%h rw=%0d exp ctl=6 A=11 B=22 rw=0", ALUControl, A, B, RegWrite); end
        send(32'h012A402A, 32'h11, 32'h22);
        n_checks++; if ({ALUControl, RegWrite} !== {4'd7, 1'b1}) begin n_errors++; $display("FAIL slt: got ctl=%0d rw=%0d exp ctl=7 rw=1", ALUControl, RegWrite); end
        send(32'h01200008, 32'h44, 32'h22);
        n_checks++; if ({ALUControl, A, B, RegWrite} !== {4'd8, 32'h44, 32'd0, 1'b0}) begin n_errors++; $display("FAIL jr: got ctl=%0d A=%h B=%h rw=%0d exp ctl=8 A=44 B=0 rw=0", ALUControl, A, B, RegWrite); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        OutReady = 1'b0;
        Instr = 32'h012A4020; RsData = 32'd1; RtData = 32'd2; InValid = 1'b1;
        tick();
        Instr = 32'h012A4022; RsData = 32'd3; RtData = 32'd4;
        n_checks++; if (InReady !== 1'b1) begin n_errors++; $display("FAIL b2b_second_ready: got %0d exp 1", InReady); end
        tick();
        Instr = 32'h012A4024; RsData = 32'd5; RtData = 32'd6;
        n_checks++; if (InReady !== 1'b0) begin n_errors++; $display("FAIL b2b_third_blocked: got %0d exp 0", InReady); end
        n_checks++; if ({OutValid, ALUControl, A, B} !== {1'b1, 4'd2, 32'd1, 32'd2}) begin n_errors++; $display("FAIL b2b_first_out: got v=%0d ctl=%0d A=%h B=%h exp v=1 ctl=2 A=1 B=2", OutValid, ALUControl, A, B); end
        tick();
        n_checks++; if ({OutValid, ALUControl, A, B, InReady, IssueCount} !== {1'b1, 4'd2, 32'd1, 32'd2, 1'b0, 16'd0}) begin n_errors++; $display("FAIL b2b_stall_stable: got v=%0d ctl=%0d A=%h B=%h rdy=%0d cnt=%0d exp v=1 ctl=2 A=1 B=2 rdy=0 cnt=0", OutValid, ALUControl, A, B, InReady, IssueCount); end
        OutReady = 1'b1;
        tick();
        n_checks++; if ({OutValid, ALUControl, A, B, IssueCount, InReady} !== {1'b1, 4'd6, 32'd3, 32'd4, 16'd1, 1'b1}) begin n_errors++; $display("FAIL b2b_second_out: got v=%0d ctl=%0d A=%h B=%h cnt=%0d rdy=%0d exp v=1 ctl=6 A=3 B=4 cnt=1 rdy=1", OutValid, ALUControl, A, B, IssueCount, InReady); end
        tick();
        InValid = 1'b0;
        n_checks++; if ({OutValid, ALUControl, A, B, IssueCount} !== {1'b1, 4'd0, 32'd5, 32'd6, 16'd2}) begin n_errors++; $display("FAIL b2b_third_out: got v=%0d ctl=%0d A=%h B=%h cnt=%0d exp v=1 ctl=0 A=5 B=6 cnt=2", OutValid, ALUControl, A, B, IssueCount); end
        tick();
        n_checks++; if ({OutValid, IssueCount} !== {1'b0, 16'd3}) begin n_errors++; $display("FAIL b2b_drain: got v=%0d cnt=%0d exp v=0 cnt=3", OutValid, IssueCount); end
    endtask

    task automatic test_flush();
        apply_reset();
        OutReady = 1'b0;
        send(32'h012A4020, 32'd1, 32'd2);
        send(32'h012A4022, 32'd3, 32'd4);
        Instr = 32'h012A4025; RsData = 32'd7; RtData = 32'd8;
        InValid = 1'b1;
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        InValid = 1'b0;
        n_checks++; if ({OutValid, InReady, IssueCount} !== {1'b0, 1'b1, 16'd0}) begin n_errors++; $display("FAIL flush_clear: got v=%0d rdy=%0d cnt=%0d exp v=0 rdy=1 cnt=0", OutValid, InReady, IssueCount); end
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (OutValid !== 1'b0) begin n_errors++; $display("FAIL flush_no_ghost: cycle %0d got v=%0d exp 0", i, OutValid); end
        end
        send(32'h012A4020, 32'd1, 32'd2);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        n_checks++; if ({OutValid, IssueCount} !== {1'b0, 16'd1}) begin n_errors++; $display("FAIL flush_counts_xfer: got v=%0d cnt=%0d exp v=0 cnt=1", OutValid, IssueCount); end
    endtask

    task automatic test_rst_flush();
        apply_reset();
        OutReady = 1'b1;
        send(32'h012A4020, 32'd1, 32'd2);
        tick();
        OutReady = 1'b0;
        send(32'h2128FFFF, 32'd1, 32'd2);
        send(32'h3128FFFF, 32'd1, 32'd2);
        Rst = 1'b1;
        Flush = 1'b1;
        InValid = 1'b1;
        OutReady = 1'b1;
        tick();
        n_checks++; if ({OutValid, InReady, ALUControl, A, B, WriteReg, RegWrite, Illegal, IssueCount} !== '0) begin n_errors++; $display("FAIL rst_flush: got v=%0d rdy=%0d ctl=%0d A=%h B=%h wr=%0d rw=%0d ill=%0d cnt=%0d exp all 0", OutValid, InReady, ALUControl, A, B, WriteReg, RegWrite, Illegal, IssueCount); end
        Rst = 1'b0;
        Flush = 1'b0;
        InValid = 1'b0;
        tick();
        n_checks++; if ({OutValid, IssueCount} !== {1'b0, 16'd0}) begin n_errors++; $display("FAIL rst_flush_after: got v=%0d cnt=%0d exp v=0 cnt=0", OutValid, IssueCount); end
    endtask

    task automatic test_wrap();
        apply_reset();
        OutReady = 1'b1;
        Instr = 32'h012A4020;
        InValid = 1'b1;
        repeat (65536) @(posedge Clk);
        @(negedge Clk);
        n_checks++; if ({OutValid, IssueCount} !== {1'b1, 16'hFFFF}) begin n_errors++; $display("FAIL wrap_pre: got v=%0d cnt=%h exp v=1 cnt=ffff", OutValid, IssueCount); end
        tick();
        InValid = 1'b0;
        n_checks++; if (IssueCount !== 16'h0000) begin n_errors++; $display("FAIL wrap: got %h exp 0000", IssueCount); end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_add();
        test_imm();
        test_misc_decode();
        test_back_to_back();
        test_flush();
        test_rst_flush();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
